// File: rtl/seq_mul_div_pkg.sv
// Shared constants and types for the sequential 4-bit multiplier/divider.
package seq_mul_div_pkg;

    localparam int W     = 4;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mul_div_ripple_adder_subtractor.sv
// W-bit ripple-carry adder/subtractor: S = A + (B ^ {W{M}}) + M, Cout is the final carry.
module ripple_adder_subtractor
    import seq_mul_div_pkg::*;
(
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         M,
    output logic [W-1:0] S,
    output logic         Cout
);

    logic [W:0] carry;

    assign carry[0] = M;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            logic b_eff;
            assign b_eff         = B[gi] ^ M;
            assign S[gi]         = A[gi] ^ b_eff ^ carry[gi];
            assign carry[gi + 1] = (A[gi] & b_eff) | (carry[gi] & (A[gi] ^ b_eff));
        end
    endgenerate

    assign Cout = carry[W];

endmodule

// File: rtl/seq_mul_div.sv
// Sequential unsigned shift-add multiplier / restoring divider, one adder step per clock.
// Define SEQ_MUL_DIV_DIV_EN to enable the divide operation; otherwise every start multiplies.
module seq_mul_div
    import seq_mul_div_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           op,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] R,
    output logic           dz
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [W-1:0]     opnd_reg, opnd_next;
    logic [W-1:0]     hi_reg, hi_next;
    logic [W-1:0]     lo_reg, lo_next;
    logic [2*W-1:0]   r_reg, r_next;

    logic [W-1:0]     add_a, add_b, add_s;
    logic             add_m, add_cout;
    logic             in_run;
    logic             is_div;

    assign in_run = (state_reg == ST_RUN);

`ifdef SEQ_MUL_DIV_DIV_EN
    logic         op_reg, op_next;
    logic         dz_reg, dz_next;
    logic         div_t;
    logic [W-1:0] div_rem, div_q;

    // Remainder/quotient pair shifted left by one, with the bit falling out of rem kept aside.
    assign div_t   = hi_reg[W-1];
    assign div_rem = {hi_reg[W-2:0], lo_reg[W-1]};
    assign div_q   = {lo_reg[W-2:0], 1'b0};
    assign is_div  = (op_reg == OP_DIV);
    assign dz      = dz_reg;
`else
    logic unused_op;
    assign unused_op = op;
    assign is_div    = 1'b0;
    assign dz        = 1'b0;
`endif

    // Adder inputs are driven separately so the step logic below only consumes S/Cout.
    always_comb begin
        add_a = '0;
        add_b = '0;
        add_m = 1'b0;
        if (in_run) begin
`ifdef SEQ_MUL_DIV_DIV_EN
            if (is_div) begin
                add_a = div_rem;
                add_b = opnd_reg;
                add_m = 1'b1;
            end else begin
                add_a = hi_reg;
                add_b = lo_reg[0] ? opnd_reg : '0;
            end
`else
            add_a = hi_reg;
            add_b = lo_reg[0] ? opnd_reg : '0;
`endif
        end
    end

    ripple_adder_subtractor u_adder (
        .A    (add_a),
        .B    (add_b),
        .M    (add_m),
        .S    (add_s),
        .Cout (add_cout)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        opnd_next  = opnd_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        r_next     = r_reg;
`ifdef SEQ_MUL_DIV_DIV_EN
        op_next    = op_reg;
        dz_next    = dz_reg;
`endif
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                    cnt_next   = CNT_W'(W);
                    hi_next    = '0;
                    r_next     = '0;
`ifdef SEQ_MUL_DIV_DIV_EN
                    op_next    = op;
                    dz_next    = 1'b0;
                    opnd_next  = (op == OP_DIV) ? B : A;
                    lo_next    = (op == OP_DIV) ? A : B;
                    if (op == OP_DIV && B == '0) begin
                        state_next = ST_DONE;
                        r_next     = {A, {W{1'b1}}};
                        dz_next    = 1'b1;
                    end
`else
                    opnd_next  = A;
                    lo_next    = B;
`endif
                end else if (state_reg == ST_DONE) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (is_div) begin
`ifdef SEQ_MUL_DIV_DIV_EN
                    // Restore unless the shifted remainder reached the divisor.
                    if (div_t | add_cout) begin
                        hi_next = add_s;
                        lo_next = {div_q[W-1:1], 1'b1};
                    end else begin
                        hi_next = div_rem;
                        lo_next = div_q;
                    end
`endif
                end else begin
                    {hi_next, lo_next} = {add_cout, add_s, lo_reg[W-1:1]};
                end
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                    r_next     = {hi_next, lo_next};
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            opnd_reg  <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            r_reg     <= '0;
`ifdef SEQ_MUL_DIV_DIV_EN
            op_reg    <= 1'b0;
            dz_reg    <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            opnd_reg  <= opnd_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            r_reg     <= r_next;
`ifdef SEQ_MUL_DIV_DIV_EN
            op_reg    <= op_next;
            dz_reg    <= dz_next;
`endif
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign done = (state_reg == ST_DONE);
    assign R    = r_reg;

endmodule
